// File: rtl/decode_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO carrying PC/NPC/instr/prediction,
// with flush, freeze (pop hold), almost-full and sticky halt blocking of further fetch.
module decode_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          WORD_W   = 32,
  parameter int          AFULL_TH = DEPTH - 1,
  parameter logic [5:0]  HALT_OP  = 6'h3F,
  localparam int         PW       = $clog2(DEPTH),
  localparam int         CW       = PW + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_npc,
  input  logic [WORD_W-1:0] in_instr,
  input  logic [WORD_W-1:0] in_pred_addr,
  input  logic              in_branch_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_npc,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pred_addr,
  output logic              out_branch_taken,
  output logic [CW-1:0]     count,
  output logic              afull,
  output logic              halt_seen
);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pred_addr;
    logic              taken;
  } entry_t;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          push, pop, is_halt;

  // in_ready depends on state only, so a full queue refuses a push even on a pop cycle
  assign in_ready  = (count != FULL_CNT) & ~halt_seen;
  assign out_valid = (count != '0);
  assign afull     = (count >= AFULL_CNT);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~freeze & ~flush;
  assign is_halt   = (in_instr[WORD_W-1 -: 6] == HALT_OP);

  assign head             = mem[rd_ptr];
  assign out_pc           = out_valid ? head.pc        : '0;
  assign out_npc          = out_valid ? head.npc       : '0;
  assign out_instr        = out_valid ? head.instr     : '0;
  assign out_pred_addr    = out_valid ? head.pred_addr : '0;
  assign out_branch_taken = out_valid & head.taken;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && is_halt) halt_seen <= 1'b1;
    end
  end

  // Payload storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, npc: in_npc, instr: in_instr,
                               pred_addr: in_pred_addr, taken: in_branch_taken};
  end

endmodule

// File: doc/decode_fetch_queue.md
Name: decode_fetch_queue

Overview:
- Parametrised instruction queue between the fetch latch and the decode stage. It generalises the single fetch/decode pipeline register into a DEPTH-entry FIFO.
- Each entry carries PC, NPC, instruction word, branch-prediction bit and predicted target.
- Fetch keeps pushing while decode is frozen; decode pops one entry per consumed cycle.
- Adds flush, freeze, almost-full back-pressure and sticky halt blocking, none of which a single latch provides.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- WORD_W, 32, width of PC/NPC/instruction/predicted-target fields.
- AFULL_TH, DEPTH-1, occupancy at or above which afull asserts.
- HALT_OP, 6'h3F, opcode (instr[WORD_W-1:WORD_W-6]) treated as halt.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- flush  in  1  discard all entries and any same-cycle push.
- freeze  in  1  hold head; blocks pop only.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue accepts the entry this cycle.
- in_pc, in_npc, in_instr, in_pred_addr  in  WORD_W each  fetch fields.
- in_branch_taken  in  1  fetch prediction bit.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes head this cycle (decode drives ihit & ~stall).
- out_pc, out_npc, out_instr, out_pred_addr  out  WORD_W each  head fields.
- out_branch_taken  out  1  head prediction bit.
- count  out  $clog2(DEPTH)+1  occupancy.
- afull  out  1  count >= AFULL_TH.
- halt_seen  out  1  a halt entry has been accepted since last flush/reset.

Behaviour:
- Reset: RST sampled on rising edge (synchronous, active-high). Clears rd_ptr, wr_ptr, count and halt_seen to 0, so out_valid=0, in_ready=1, afull=0.
- Entry storage is not reset; out_* fields read 0 while empty (gated by out_valid).
- Storage: circular buffer, rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count tracked separately (distinguishes full from empty).
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~freeze & ~flush.
- in_ready = (count != DEPTH) & ~halt_seen, purely combinational from state. There is no out_ready->in_ready path, so a full queue rejects a push even when a pop occurs that cycle.
- out_valid = (count != 0). out_* fields come from entry[rd_ptr] combinationally.
- Latency: an entry pushed in cycle N appears at the head no earlier than cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Flush has priority over everything. Next cycle: count=0, rd_ptr=wr_ptr=0, halt_seen=0. A same-cycle push is dropped.
- Flush together with RST behaves as reset.
- Freeze: pop suppressed, head held; pushes continue until full.
- Halt: a push whose instr opcode equals HALT_OP sets halt_seen next cycle. in_ready then stays 0 until flush/reset. The halt entry and entries ahead of it still drain normally.
- Reset mid-operation: all entries discarded immediately (next cycle empty). No partial state survives.
- No overflow/underflow is possible by construction. The bench asserts that pushing when !in_ready and popping when !out_valid never change state.

Test Plan:
- Reset then fill: RST 1 cycle, push instr 0x20010001..0x20010004 with PC 0x0,0x4,0x8,0xC, out_ready=0 -> count=4, in_ready=0, afull=1 after 3rd push, out_instr=0x20010001.
- Drain with wrap: from full, pop 2, push 2 (PC 0x10,0x14), pop 4 -> heads appear in order 0x8,0xC,0x10,0x14; count ends 0, out_valid=0.
- Simultaneous push/pop at count=2 for 6 cycles -> count stays 2, order preserved across pointer wrap.
- Freeze: count=3, freeze=1, out_ready=1 for 3 cycles with in_valid=1 -> head unchanged, count=4, fourth push refused (in_ready=0).
- Flush with push: count=3, flush=1 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, pushed entry absent, halt_seen=0.
- Halt: push 0xFC000000 then in_valid=1 continuously -> halt_seen=1, in_ready=0; halt drains as head; flush restores in_ready=1.
